// File: rtl/imem_loader.sv
// Boot-time loader: turns a framed, checksummed byte stream into 32-bit
// instruction-memory writes and holds the core in stall until a valid program is in place.
module imem_loader #(
  parameter int MEM_BYTES = 76
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  byte_in_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  err_code_o,
  output logic        core_hold_o
);

  localparam logic [31:0] MAX_WORDS = 32'(MEM_BYTES / 4);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic [23:0] wbuf_q, wbuf_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        accept;
  logic [15:0] n_words;

  // done/error are sticky by construction: DONE and ERR are left only on an accepted start.
  assign byte_ready_o = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA)   || (state_q == S_CSUM);
  assign busy_o       = byte_ready_o;
  assign done_o       = (state_q == S_DONE);
  assign error_o      = (state_q == S_ERR);
  assign core_hold_o  = (state_q != S_DONE);
  assign err_code_o   = err_code_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

  assign accept  = byte_valid_i && byte_ready_o;
  assign n_words = {byte_in_i, len_q[7:0]};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    csum_d      = csum_q;
    wbuf_d      = wbuf_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_code_d  = err_code_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d    = S_LEN_LO;
          err_code_d = 2'b00;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          csum_d     = '0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = byte_in_i;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = byte_in_i;
          if ({16'd0, n_words} > MAX_WORDS) begin
            state_d    = S_ERR;
            err_code_d = 2'b01;
          end else if (n_words == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ byte_in_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: wbuf_d[7:0]   = byte_in_i;
            2'd1: wbuf_d[15:8]  = byte_in_i;
            2'd2: wbuf_d[23:16] = byte_in_i;
            default: begin
              // Fourth byte completes the word; it goes straight to the write register.
              mem_we_d    = 1'b1;
              mem_addr_d  = {46'd0, word_cnt_q, 2'b00};
              mem_wdata_d = {byte_in_i, wbuf_q};
              word_cnt_d  = word_cnt_q + 16'd1;
              if (word_cnt_q == len_q - 16'd1) state_d = S_CSUM;
            end
          endcase
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (byte_in_i == csum_q) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ERR;
            err_code_d = 2'b10;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      csum_q      <= '0;
      wbuf_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      csum_q      <= csum_d;
      wbuf_q      <= wbuf_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_code_q  <= err_code_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good frame, bad checksum, oversize length,
// empty program, throttled stream and reset in the middle of a load.
module tb_imem_loader;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [7:0]  byte_in_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        busy_o, done_o, error_o, core_hold_o;
  logic [1:0]  err_code_o;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int base;

  logic [7:0] frame [0:10];

  imem_loader #(.MEM_BYTES(76)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .byte_in_i(byte_in_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .err_code_o(err_code_o), .core_hold_o(core_hold_o)
  );

  always #5 clk_i = ~clk_i;

  // Each write strobe lasts one cycle, so one negedge sample sees it exactly once.
  always @(negedge clk_i) begin
    if (mem_we_o) begin
      wr_cnt <= wr_cnt + 1;
      $display("write: addr=%h data=%h", mem_addr_o, mem_wdata_o);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 64'(byte_ready_o), 64'd0);
    chk({tag, "_we"},    64'(mem_we_o),     64'd0);
    chk({tag, "_addr"},  mem_addr_o,        64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata_o),  64'd0);
    chk({tag, "_busy"},  64'(busy_o),       64'd0);
    chk({tag, "_done"},  64'(done_o),       64'd0);
    chk({tag, "_error"}, 64'(error_o),      64'd0);
    chk({tag, "_code"},  64'(err_code_o),   64'd0);
    chk({tag, "_hold"},  64'(core_hold_o),  64'd1);
  endtask

  // Called at a negedge; returns at the negedge after start was sampled.
  task automatic do_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("start_busy",  64'(busy_o),       64'd1);
    chk("start_ready", 64'(byte_ready_o), 64'd1);
    chk("start_done",  64'(done_o),       64'd0);
    chk("start_error", 64'(error_o),      64'd0);
    chk("start_code",  64'(err_code_o),   64'd0);
    chk("start_hold",  64'(core_hold_o),  64'd1);
  endtask

  // Called at a negedge; returns at the negedge after the byte was transferred.
  task automatic send_byte(input logic [7:0] b);
    int k;
    byte_in_i    = b;
    byte_valid_i = 1'b1;
    k = 0;
    while (!byte_ready_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    if (!byte_ready_o) chk("ready_timeout", 64'(byte_ready_o), 64'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    $display("byte %h sent", b);
  endtask

  task automatic send_frame(input logic [7:0] csum, input bit gap, input int upto);
    for (int i = 0; i < upto; i++) begin
      send_byte(i == 10 ? csum : frame[i]);
      if (i == 5) begin
        chk("w0_we",   64'(mem_we_o),    64'd1);
        chk("w0_addr", mem_addr_o,       64'd0);
        chk("w0_data", 64'(mem_wdata_o), 64'h00A00F93);
      end
      if (i == 9) begin
        chk("w1_we",   64'(mem_we_o),    64'd1);
        chk("w1_addr", mem_addr_o,       64'd4);
        chk("w1_data", 64'(mem_wdata_o), 64'h00000F13);
      end
      if (gap) @(negedge clk_i);
    end
  endtask

  initial begin
    frame[0] = 8'h02; frame[1] = 8'h00; frame[2] = 8'h93; frame[3] = 8'h0F;
    frame[4] = 8'hA0; frame[5] = 8'h00; frame[6] = 8'h13; frame[7] = 8'h0F;
    frame[8] = 8'h00; frame[9] = 8'h00; frame[10] = 8'h20;
    rst_ni = 1'b0; start_i = 1'b0; byte_in_i = 8'h00; byte_valid_i = 1'b0;

    // Reset values, and no acceptance in IDLE
    #12;
    chk_reset("rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    byte_valid_i = 1'b1; byte_in_i = 8'h55;
    repeat (3) @(negedge clk_i);
    chk("idle_ready", 64'(byte_ready_o), 64'd0);
    chk("idle_busy",  64'(busy_o),       64'd0);
    byte_valid_i = 1'b0;

    // Good frame at full rate
    base = wr_cnt;
    do_start();
    send_frame(8'h20, 1'b0, 11);
    chk("good_done",  64'(done_o),       64'd1);
    chk("good_hold",  64'(core_hold_o),  64'd0);
    chk("good_code",  64'(err_code_o),   64'd0);
    chk("good_busy",  64'(busy_o),       64'd0);
    chk("good_ready", 64'(byte_ready_o), 64'd0);
    chk("good_nwr",   64'(wr_cnt - base), 64'd2);

    // Same frame, wrong checksum
    base = wr_cnt;
    do_start();
    send_frame(8'h21, 1'b0, 11);
    chk("bad_error", 64'(error_o),      64'd1);
    chk("bad_done",  64'(done_o),       64'd0);
    chk("bad_code",  64'(err_code_o),   64'd2);
    chk("bad_hold",  64'(core_hold_o),  64'd1);
    chk("bad_ready", 64'(byte_ready_o), 64'd0);
    chk("bad_nwr",   64'(wr_cnt - base), 64'd2);

    // Length 20 exceeds 19 words
    base = wr_cnt;
    do_start();
    send_byte(8'h14);
    send_byte(8'h00);
    chk("big_error", 64'(error_o),      64'd1);
    chk("big_code",  64'(err_code_o),   64'd1);
    chk("big_ready", 64'(byte_ready_o), 64'd0);
    byte_valid_i = 1'b1; byte_in_i = 8'h93;
    repeat (3) @(negedge clk_i);
    byte_valid_i = 1'b0;
    chk("big_ready2", 64'(byte_ready_o), 64'd0);
    chk("big_error2", 64'(error_o),      64'd1);
    chk("big_nwr",    64'(wr_cnt - base), 64'd0);

    // Empty program
    base = wr_cnt;
    do_start();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("empty_done", 64'(done_o),      64'd1);
    chk("empty_hold", 64'(core_hold_o), 64'd0);
    chk("empty_nwr",  64'(wr_cnt - base), 64'd0);
    do_start();

    // Throttled stream continues the load just started
    base = wr_cnt;
    send_frame(8'h20, 1'b1, 11);
    chk("slow_done", 64'(done_o),      64'd1);
    chk("slow_hold", 64'(core_hold_o), 64'd0);
    chk("slow_code", 64'(err_code_o),  64'd0);
    chk("slow_nwr",  64'(wr_cnt - base), 64'd2);

    // Reset in the middle of the second word
    base = wr_cnt;
    do_start();
    send_frame(8'h20, 1'b0, 6);
    #1 rst_ni = 1'b0;
    #1;
    chk_reset("midrst");
    chk("midrst_nwr", 64'(wr_cnt - base), 64'd1);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("post_we",    64'(mem_we_o),    64'd0);
    chk("post_busy",  64'(busy_o),      64'd0);
    chk("post_hold",  64'(core_hold_o), 64'd1);
    chk("post_nwr",   64'(wr_cnt - base), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the byte-addressed, little-endian instruction memory. Accepts a framed byte stream over a valid/ready handshake and assembles each 4-byte group into a 32-bit word write at word-aligned addresses starting at 0. It checks the frame length and an XOR checksum, and holds the core in stall until a complete, valid program has been written. It sits between the host or boot-UART byte source and the instruction memory's write port, and is the write-side counterpart of the combinational fetch path.

## Interface
Parameters:
- MEM_BYTES, 76: instruction memory size in bytes, a multiple of 4. MAX_WORDS = MEM_BYTES/4.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load. Honoured only in IDLE, DONE or ERR.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte. A transfer occurs on an edge where byte_valid && byte_ready.
- mem_we  out  1  one-cycle word-write strobe to the instruction memory.
- mem_addr  out  64  byte address of the word write; always a multiple of 4.
- mem_wdata  out  32  write word, {b3,b2,b1,b0}, where b0 is the first byte received for that word.
- busy  out  1  a load is in progress.
- done  out  1  sticky success flag; cleared by the next accepted start.
- error  out  1  sticky failure flag; cleared by the next accepted start.
- err_code  out  2  01 = length too large, 10 = checksum mismatch, 00 = none.
- core_hold  out  1  stall request to the core; low only in DONE.

## Operation
Frame format, in stream order:
- LEN_LO, LEN_HI: word count N, little-endian, 16 bits.
- 4·N payload bytes.
- CSUM: XOR of all payload bytes. Length bytes are excluded from the checksum.

States:
- IDLE (reset state).
  - byte_ready=0.
  - start → LEN_LO. On that transition, clear done, error and err_code; zero the word counter, byte counter and running XOR; set busy=1.
- LEN_LO: byte_ready=1. Accept → store low byte → LEN_HI.
- LEN_HI: byte_ready=1. Accept → store high byte, then:
  - N > MAX_WORDS → ERR with err_code=01.
  - N == 0 → CSUM.
  - otherwise → DATA.
- DATA: byte_ready=1. Each accepted byte is shifted into lane (byte counter mod 4) and XORed into the running checksum. On the 4th byte of a word:
  - next cycle: mem_we=1, mem_addr=4·word index, mem_wdata=assembled word;
  - word index increments;
  - after word N−1 the state moves to CSUM.
- CSUM: byte_ready=1. Accept → compare with the running XOR.
  - Equal → DONE.
  - Not equal → ERR with err_code=10.
- DONE: busy=0, done=1, core_hold=0, byte_ready=0. start → LEN_LO, which re-asserts core_hold.
- ERR: busy=0, error=1, core_hold=1, byte_ready=0. start → LEN_LO.

Rules:
- start is ignored while busy.
- byte_valid is ignored while byte_ready=0.
- Words already written before an error are not rolled back.
- The word-index counter is 16 bits and cannot wrap, because N ≤ MAX_WORDS is enforced before the first write.
- mem_addr and mem_wdata are registered and hold their last written value between strobes.

## Timing
Reset values (asynchronous, take effect immediately when reset goes low):
- state=IDLE
- byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
- busy=0, done=0, error=0, err_code=00
- core_hold=1

Cycle-level behaviour:
- start sampled at edge t → byte_ready=1 and busy=1 from cycle t+1.
- Write latency: the 4th byte accepted at edge t → mem_we=1 during cycle t+1, for exactly one cycle.
- byte_ready stays high through DATA; a byte may be accepted in the same cycle mem_we is high.
- Full-rate throughput: one byte per cycle. Gaps in byte_valid stall the state without penalty.
- Checksum byte accepted at edge t → done or error and the state change visible in cycle t+1. core_hold falls in cycle t+1 on success.
- The final word's mem_we always precedes the done flag.
- Reset asserted mid-load: immediate return to reset values; any partially assembled word is discarded and no write is issued.

## Test plan
- Reset → all outputs at reset values; core_hold=1; byte_ready=0 before start.
- start, then stream 02 00 93 0F A0 00 13 0F 00 00 20 at full rate:
  - mem_we pulses at addr 0 with data 0x00A00F93 and at addr 4 with data 0x00000F13;
  - done=1, core_hold=0, err_code=00.
- Same frame with CSUM=0x21 → both writes still occur; error=1, err_code=10, core_hold=1, byte_ready=0.
- Stream 14 00 (N=20 > 19 for MEM_BYTES=76) → ERR the cycle after LEN_HI; err_code=01; no mem_we; later bytes not accepted.
- Stream 00 00 00 → done=1 with no mem_we; then a second start clears done and re-asserts core_hold and busy.
- Frame from the second scenario with byte_valid toggling every other cycle, then a repeat with reset asserted after the 6th byte:
  - first run: identical writes and result;
  - second run: reset values return immediately; only the addr-0 write has occurred.
